// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - MIPS register file + operand fetch feeding a single-entry alu input buffer
// Optional feature: ALU_OPSTAGE_BYPASS_EN (same-cycle write-back forwarded into an accept)
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  input  logic [15:0]       imm,
  input  logic              use_imm,
  input  logic [1:0]        op_sel,
  input  logic              flush,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [1:0]        sel
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic [DATA_W-1:0] imm_ext;
  logic              wb_hit;
  logic              accept;

  assign wb_hit   = wb_en && (wb_addr != '0);
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign imm_ext  = {{(DATA_W-16){imm[15]}}, imm};

  always_comb begin
    rs_val = (rs_addr == '0) ? '0 : regs[rs_addr];
    rt_val = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef ALU_OPSTAGE_BYPASS_EN
    // forward the write-back landing this edge so the accept sees the new value
    if (wb_hit && (wb_addr == rs_addr)) rs_val = wb_data;
    if (wb_hit && (wb_addr == rt_addr)) rt_val = wb_data;
`else
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // a/b/sel are a snapshot taken at accept; stalls never refresh them
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      a         <= '0;
      b         <= '0;
      sel       <= 2'b00;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      a         <= rs_val;
      b         <= use_imm ? imm_ext : rt_val;
      sel       <= op_sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - directed vector bench for alu_operand_stage
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, use_imm, flush, wb_en, out_valid, out_ready;
  logic [4:0]  rs_addr, rt_addr, wb_addr;
  logic [15:0] imm;
  logic [1:0]  op_sel, sel;
  logic [31:0] wb_data, a, b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_operand_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .imm(imm), .use_imm(use_imm),
    .op_sel(op_sel), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .sel(sel)
  );

  typedef struct {
    logic        rst;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        in_valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [15:0] imm;
    logic        use_imm;
    logic [1:0]  op_sel;
    logic        out_ready;
    logic        flush;
    logic        e_ir;
    logic        e_ov;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [1:0]  e_sel;
  } vec_t;

  vec_t vecs[$];

`ifdef ALU_OPSTAGE_BYPASS_EN
  localparam logic [31:0] BYP = 32'hA0A0_A0A0;
`else
  localparam logic [31:0] BYP = 32'h0000_0000;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; wb_en = v.wb_en; wb_addr = v.wb_addr; wb_data = v.wb_data;
    in_valid = v.in_valid; rs_addr = v.rs; rt_addr = v.rt; imm = v.imm;
    use_imm = v.use_imm; op_sel = v.op_sel; out_ready = v.out_ready; flush = v.flush;
  endtask

  initial begin
    vec_t idle;
    idle = '{1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 16'h0, 1'b0, 2'd0, 1'b1, 1'b0,
             1'b1, 1'b0, 32'h0, 32'h0, 2'd0};
    drive(idle);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset a", a, 32'h0);
    check("reset b", b, 32'h0);
    check("reset sel", {30'd0, sel}, 32'd0);
    check("reset in_ready", {31'd0, in_ready}, 32'd1);

    //          rst  wb  wba    wbd            iv   rs     rt     imm       ui   op    ordy flush  ir   ov   a              b              sel
    vecs.push_back('{1'b0,1'b1,5'd1,32'h0000_03E8,1'b0,5'd0, 5'd0, 16'h0000,1'b0,2'd0,1'b1,1'b0, 1'b1,1'b0,32'h0,         32'h0,         2'd0});
    vecs.push_back('{1'b0,1'b1,5'd2,32'h0000_07D0,1'b0,5'd0, 5'd0, 16'h0000,1'b0,2'd0,1'b1,1'b0, 1'b1,1'b0,32'h0,         32'h0,         2'd0});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd1, 5'd2, 16'h0000,1'b0,2'd0,1'b1,1'b0, 1'b1,1'b1,32'h0000_03E8,32'h0000_07D0,2'd0});
    vecs.push_back('{1'b0,1'b1,5'd0,32'hFFFF_FFFF,1'b0,5'd0, 5'd0, 16'h0000,1'b0,2'd0,1'b1,1'b0, 1'b1,1'b0,32'h0000_03E8,32'h0000_07D0,2'd0});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd0, 5'd0, 16'h0000,1'b0,2'd2,1'b1,1'b0, 1'b1,1'b1,32'h0,         32'h0,         2'd2});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd1, 5'd0, 16'h8001,1'b1,2'd1,1'b1,1'b0, 1'b1,1'b1,32'h0000_03E8,32'hFFFF_8001,2'd1});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd2, 5'd0, 16'h7FFF,1'b1,2'd3,1'b1,1'b0, 1'b1,1'b1,32'h0000_07D0,32'h0000_7FFF,2'd3});
    vecs.push_back('{1'b0,1'b1,5'd4,32'h1111_1111,1'b0,5'd0, 5'd0, 16'h0000,1'b0,2'd0,1'b1,1'b0, 1'b1,1'b0,32'h0000_07D0,32'h0000_7FFF,2'd3});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd4, 5'd1, 16'h0000,1'b0,2'd2,1'b1,1'b0, 1'b1,1'b1,32'h1111_1111,32'h0000_03E8,2'd2});
    vecs.push_back('{1'b0,1'b1,5'd4,32'h4422_0EA1,1'b1,5'd4, 5'd2, 16'h0000,1'b0,2'd0,1'b0,1'b0, 1'b0,1'b1,32'h1111_1111,32'h0000_03E8,2'd2});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd4, 5'd2, 16'h0000,1'b0,2'd0,1'b0,1'b0, 1'b0,1'b1,32'h1111_1111,32'h0000_03E8,2'd2});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd4, 5'd2, 16'h0000,1'b0,2'd0,1'b1,1'b0, 1'b1,1'b1,32'h4422_0EA1,32'h0000_07D0,2'd0});
    vecs.push_back('{1'b0,1'b1,5'd3,32'hA0A0_A0A0,1'b1,5'd3, 5'd3, 16'h0000,1'b0,2'd1,1'b1,1'b0, 1'b1,1'b1,BYP,          BYP,           2'd1});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd3, 5'd0, 16'h0000,1'b0,2'd0,1'b1,1'b0, 1'b1,1'b1,32'hA0A0_A0A0,32'h0,         2'd0});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd1, 5'd2, 16'h0000,1'b0,2'd3,1'b0,1'b1, 1'b0,1'b0,32'hA0A0_A0A0,32'h0,         2'd0});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd1, 5'd2, 16'h0000,1'b0,2'd3,1'b0,1'b0, 1'b1,1'b1,32'h0000_03E8,32'h0000_07D0,2'd3});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b0,5'd0, 5'd0, 16'h0000,1'b0,2'd0,1'b0,1'b0, 1'b0,1'b1,32'h0000_03E8,32'h0000_07D0,2'd3});
    vecs.push_back('{1'b1,1'b1,5'd5,32'hDEAD_BEEF,1'b1,5'd1, 5'd2, 16'h0000,1'b0,2'd1,1'b0,1'b0, 1'b0,1'b0,32'h0,         32'h0,         2'd0});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd1, 5'd2, 16'h0000,1'b0,2'd0,1'b1,1'b0, 1'b1,1'b1,32'h0,         32'h0,         2'd0});
    vecs.push_back('{1'b0,1'b0,5'd0,32'h0,        1'b1,5'd5, 5'd5, 16'h0000,1'b0,2'd2,1'b1,1'b0, 1'b1,1'b1,32'h0,         32'h0,         2'd2});

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, {31'd0, vecs[i].e_ir});
      @(posedge clk);
      #1;
      check($sformatf("v%0d out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      check($sformatf("v%0d a", i), a, vecs[i].e_a);
      check($sformatf("v%0d b", i), b, vecs[i].e_b);
      check($sformatf("v%0d sel", i), {30'd0, sel}, {30'd0, vecs[i].e_sel});
      @(negedge clk);
    end

    // in_ready must not follow in_valid while stalled, and back-to-back accepts stream at one per cycle
    drive(idle);
    in_valid = 1'b1; rs_addr = 5'd0; use_imm = 1'b1; imm = 16'h0005; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; #1;
    check("stall ir iv0", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; #1;
    check("stall ir iv1", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      imm = 16'(16'h0100 + k);
      @(posedge clk);
      #1;
      check($sformatf("stream%0d b", k), b, 32'h0000_0100 + k);
      check($sformatf("stream%0d ov", k), {31'd0, out_valid}, 32'd1);
      @(negedge clk);
    end
    drive(idle);
    @(posedge clk);
    #1;
    check("drain ov", {31'd0, out_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-fetch stage directly upstream of `alu`. It holds the 32-entry MIPS register file and reads two source operands, optionally substituting a sign-extended immediate for operand B. It registers `a`, `b` and `sel` into a single-entry output buffer that drives the `alu` inputs. Write-back from later stages enters through a dedicated write port.

## Interface
- `DATA_W`, 32: register and operand width.
- `ADDR_W`, 5: register address width; depth is 2^ADDR_W.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: a decoded instruction is presented.
- `in_ready` output 1: stage accepts the instruction this cycle.
- `rs_addr` input ADDR_W: source register for A.
- `rt_addr` input ADDR_W: source register for B.
- `imm` input 16: immediate field.
- `use_imm` input 1: B = sign-extended `imm` instead of reg[rt].
- `op_sel` input 2: ALU operation code, passed through to `sel`.
- `flush` input 1: discard the buffered output.
- `wb_en` input 1: write-back enable.
- `wb_addr` input ADDR_W: write-back register.
- `wb_data` input DATA_W: write-back value.
- `out_valid` output 1: `a`/`b`/`sel` are valid.
- `out_ready` input 1: downstream consumes the output this cycle.
- `a` output DATA_W: ALU operand A, registered.
- `b` output DATA_W: ALU operand B, registered.
- `sel` output 2: ALU select, registered.

## Operation
- Register file: 2^ADDR_W × DATA_W.
  - reg[0] reads 0 always.
  - Writes to address 0 are ignored.
- Write: on the clock edge when `wb_en` is high and `wb_addr` != 0, reg[wb_addr] <= `wb_data`.
- Read: combinational from the array, subject to the bypass in Configuration.
- Operand B:
  - `use_imm`=1: {{16{imm[15]}}, imm}, zero-extended to DATA_W when DATA_W > 32 is not supported (DATA_W fixed ≥ 16).
  - `use_imm`=0: reg[rt_addr].
- Output buffer: single entry.
  - `in_ready` = !`out_valid` || `out_ready`; combinational, no dependence on `in_valid`.
  - Accept (`in_valid` && `in_ready`): `a`, `b`, `sel` load; `out_valid` <= 1.
  - `out_ready` without accept: `out_valid` <= 0. `a`/`b`/`sel` keep their last values.
  - Stall (`out_valid` && !`out_ready`): `a`/`b`/`sel` are frozen. They are not refreshed by later write-backs to rs/rt; the values are a snapshot.
  - `flush`: `out_valid` <= 0 and nothing is accepted that cycle. `in_ready` is forced to 0 while `flush` is high. Flush has priority over accept and consume.
- Reset (`rst`=1 at edge): all registers in the file clear to 0; `out_valid`=0, `a`=0, `b`=0, `sel`=2'b00. Write-back and input are ignored in that cycle.
  - Reset mid-stall drops the buffered operation.
- Simultaneous write-back and accept to the same register: governed by the bypass.

## Timing
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 operation per cycle when `out_ready` is held high.
- No combinational path from `in_valid` to `in_ready`.
- `a`, `b`, `sel`, `out_valid` are driven directly from flops.
- Write-back is visible to an accept in the next cycle, or in the same cycle with bypass.

## Configuration
- `ALU_OPSTAGE_BYPASS_EN` defined: write-through bypass.
  - On an accept, if `wb_en` && `wb_addr` != 0 && `wb_addr` == `rs_addr`, A captures `wb_data`.
  - The same rule applies to `rt_addr` for B when `use_imm`=0.
- Not defined: the read returns the pre-write array contents. A same-cycle write-back is seen only by accepts in later cycles.

## Test plan
- Reset, then write reg1=0x0000_03E8 and reg2=0x0000_07D0. Accept rs=1, rt=2, op_sel=00 -> next cycle `out_valid`=1, a=0x03E8, b=0x07D0, sel=00.
- Write reg0=0xFFFF_FFFF, then accept rs=0, rt=0 -> a=0, b=0.
- Accept with use_imm=1, imm=0x8001, op_sel=01 -> b=0xFFFF_8001. With imm=0x7FFF -> b=0x0000_7FFF.
- Hold `out_ready`=0 with a=0x1111_1111 buffered. Write rs=0x4422_0EA1 -> `in_ready`=0, `a` stays 0x1111_1111. Release `out_ready` -> a new accept occurs in the same cycle.
- Same-cycle `wb_en`, wb_addr=3, wb_data=0xA0A0_A0A0 and accept rs=3 (reg3 previously 0):
  - macro defined -> a=0xA0A0_A0A0.
  - macro undefined -> a=0.
- With `out_valid`=1, assert `flush` and `in_valid` together -> next cycle `out_valid`=0. Assert `rst` mid-stall -> `out_valid`=0, a=b=0, sel=00, and a read of reg1 returns 0.
